// File: rtl/data_memory_port_if.sv
// ---------------------------------------------------------------------------
// data_memory_port_if
//
// Processor data-port bus between the Execute/Memory stages (master) and the
// data memory subsystem (slave).
//
// Signals:
//   DataAddr   master -> slave  word address of the request
//   DataOut    master -> slave  store data
//   ReadData   master -> slave  load request this cycle
//   WriteData  master -> slave  store request this cycle
//   DataIn     slave  -> master load data, valid while DataDone is high
//   DataDone   slave  -> master a request issued two cycles earlier completes
//
// Handshake: a request is valid in any cycle where ReadData or WriteData is
// high and is accepted at the posedge ending that cycle (the slave is always
// ready, there is no backpressure). The response is valid exactly two cycles
// later, flagged by DataDone for one cycle; the master must accept it
// (there is no response-side ready). DataIn is zero whenever no load
// completes.
// ---------------------------------------------------------------------------
interface data_memory_port_if #(
  parameter int WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] DataAddr;
  logic [WORD_SIZE-1:0] DataOut;
  logic                 ReadData;
  logic                 WriteData;
  logic [WORD_SIZE-1:0] DataIn;
  logic                 DataDone;

  modport master (
    output DataAddr,
    output DataOut,
    output ReadData,
    output WriteData,
    input  DataIn,
    input  DataDone
  );

  modport slave (
    input  DataAddr,
    input  DataOut,
    input  ReadData,
    input  WriteData,
    output DataIn,
    output DataDone
  );
endinterface

// File: rtl/data_memory_port.sv
// ---------------------------------------------------------------------------
// data_memory_port
//
// Data-side memory subsystem sitting behind the processor's Execute/Memory
// stages. Accepts one load or store per cycle and returns load data with a
// fixed two-cycle latency (sampled by the processor in Memory3).
//
// Address map:
//   0 .. MEM_WORDS-1   synchronous word-addressed RAM
//   LED_ADDR           LED register (read/write)
//   SW_ADDR            synchronized switch input (read-only)
//   TIMER_ADDR         free-running timer (read count / write loads count)
//   anything else      unmapped: loads return 0, stores ignored
//
// Ports:
//   Clock   clock
//   Reset   asynchronous, active-high reset
//   bus     data-port bus (slave side), see data_memory_port_if
//   SW      board switches (asynchronous to Clock)
//   LEDR    LED register contents
//
// Pipeline:
//   request cycle T  -> decoded and sampled at the posedge ending T; RAM and
//                       MMIO writes happen on that same edge, RAM read issued
//   stage A (T+1)    -> holds valid/load/region plus the MMIO read value
//   stage B (T+2)    -> holds the selected read result; drives DataIn/DataDone
// ---------------------------------------------------------------------------
module data_memory_port #(
  parameter int                   WORD_SIZE  = 16,
  parameter int                   MEM_WORDS  = 4096,
  parameter logic [WORD_SIZE-1:0] LED_ADDR   = 16'h1000,
  parameter logic [WORD_SIZE-1:0] SW_ADDR    = 16'h3000,
  parameter logic [WORD_SIZE-1:0] TIMER_ADDR = 16'h5000,
  parameter int                   NUM_LEDS   = 10
) (
  input  logic                Clock,
  input  logic                Reset,
  data_memory_port_if.slave   bus,
  input  logic [NUM_LEDS-1:0] SW,
  output logic [NUM_LEDS-1:0] LEDR
);

  localparam int ADDR_BITS = $clog2(MEM_WORDS);

  // One extra bit so the RAM bound compares cleanly even when MEM_WORDS is a
  // full power of two of the address width.
  localparam logic [WORD_SIZE:0] MEM_LIMIT = MEM_WORDS[WORD_SIZE:0];

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_LED,
    REG_SW,
    REG_TIMER
  } region_t;

  // -------------------------------------------------------------------------
  // Request decode (cycle T, combinational)
  // -------------------------------------------------------------------------
  region_t              req_region;
  logic                 req_valid;
  logic                 req_load;
  logic                 req_store;
  logic [ADDR_BITS-1:0] ram_addr;

  always_comb begin
    req_region = REG_NONE;
    if ({1'b0, bus.DataAddr} < MEM_LIMIT) begin
      req_region = REG_RAM;
    end else if (bus.DataAddr == LED_ADDR) begin
      req_region = REG_LED;
    end else if (bus.DataAddr == SW_ADDR) begin
      req_region = REG_SW;
    end else if (bus.DataAddr == TIMER_ADDR) begin
      req_region = REG_TIMER;
    end
  end

  assign req_valid = bus.ReadData | bus.WriteData;
  // A simultaneous load+store performs the store only; the load is dropped
  // and the completion returns zero data.
  assign req_load  = bus.ReadData & ~bus.WriteData;
  assign req_store = bus.WriteData;
  assign ram_addr  = bus.DataAddr[ADDR_BITS-1:0];

  // -------------------------------------------------------------------------
  // RAM: synchronous write and read on the edge ending T. A load in T+1 to an
  // address stored in T reads the array after the write has landed, so no
  // forwarding path is needed. Contents are not reset; writes are blocked
  // while Reset is held so no stray store lands during reset.
  // -------------------------------------------------------------------------
  logic [WORD_SIZE-1:0] mem [MEM_WORDS];
  logic [WORD_SIZE-1:0] ram_q;

  always_ff @(posedge Clock) begin
    if (!Reset && req_store && (req_region == REG_RAM)) begin
      mem[ram_addr] <= bus.DataOut;
    end
    ram_q <= mem[ram_addr];
  end

  // -------------------------------------------------------------------------
  // MMIO resources
  // -------------------------------------------------------------------------
  logic [NUM_LEDS-1:0]  led_q;
  logic [NUM_LEDS-1:0]  sw_meta;
  logic [NUM_LEDS-1:0]  sw_sync;
  logic [WORD_SIZE-1:0] timer_q;

  // Switch synchronizer: two flops, no other logic between them.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  // LED register: low bits of the last store to LED_ADDR.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      led_q <= '0;
    end else if (req_store && (req_region == REG_LED)) begin
      led_q <= bus.DataOut[NUM_LEDS-1:0];
    end
  end

  // Timer: a store replaces this edge's increment, so counting continues
  // from DataOut+1 on the following edge. Natural wrap at all-ones.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      timer_q <= '0;
    end else if (req_store && (req_region == REG_TIMER)) begin
      timer_q <= bus.DataOut;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // MMIO read value as seen at the edge ending T (pre-update register values).
  logic [WORD_SIZE-1:0] mmio_rdata;

  always_comb begin
    mmio_rdata = '0;
    case (req_region)
      REG_LED:   mmio_rdata = {{(WORD_SIZE-NUM_LEDS){1'b0}}, led_q};
      REG_SW:    mmio_rdata = {{(WORD_SIZE-NUM_LEDS){1'b0}}, sw_sync};
      REG_TIMER: mmio_rdata = timer_q;
      default:   mmio_rdata = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage A: request bookkeeping alongside the RAM read in flight.
  // -------------------------------------------------------------------------
  logic                 a_valid;
  logic                 a_load;
  region_t              a_region;
  logic [WORD_SIZE-1:0] a_mmio;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_valid  <= 1'b0;
      a_load   <= 1'b0;
      a_region <= REG_NONE;
      a_mmio   <= '0;
    end else begin
      a_valid  <= req_valid;
      a_load   <= req_load;
      a_region <= req_region;
      a_mmio   <= mmio_rdata;
    end
  end

  // -------------------------------------------------------------------------
  // Stage B: select the read result; zero unless a load completes so the
  // processor sees DataIn = 0 on idle and store completions.
  // -------------------------------------------------------------------------
  logic                 b_valid;
  logic [WORD_SIZE-1:0] b_data;
  logic [WORD_SIZE-1:0] a_rdata;

  always_comb begin
    a_rdata = '0;
    if (a_valid && a_load) begin
      if (a_region == REG_RAM) begin
        a_rdata = ram_q;
      end else begin
        a_rdata = a_mmio;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      b_valid <= 1'b0;
      b_data  <= '0;
    end else begin
      b_valid <= a_valid;
      b_data  <= a_rdata;
    end
  end

  assign bus.DataIn   = b_data;
  assign bus.DataDone = b_valid;
  assign LEDR         = led_q;

endmodule
